alu_sched: RTL and testbench
============================

Name: alu_sched

Overview:
- Two-requester scheduler that shares one multi-function ALU (32-bit A/B, 3-bit OP, F/OF/ZF outputs).
- Accepts operation requests over valid/ready and arbitrates round-robin.
- Drives registered operands and opcode into the ALU, waits a fixed latency, then captures F/OF/ZF.
- Returns the result on a shared response port tagged with the requester ID.

Parameters:
- WIDTH, 32, operand/result width.
- ALU_LAT, 1, cycles from the ALU-input-register update edge to the result-capture edge; legal range 1..15.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- alu_sched_clk_xi  input  1  clock, rising edge.
- alu_sched_rst_n_xi  input  1  reset, asynchronous, active-low.
- alu_sched_req0_valid_xi  input  1  requester 0 has an operation.
- alu_sched_req0_ready_xo  output  1  requester 0 operation accepted this cycle.
- alu_sched_req0_op_xi  input  3  requester 0 opcode.
- alu_sched_req0_a_xi  input  WIDTH  requester 0 operand A.
- alu_sched_req0_b_xi  input  WIDTH  requester 0 operand B.
- alu_sched_req1_valid_xi, _ready_xo, _op_xi, _a_xi, _b_xi: same as requester 0, for requester 1.
- alu_sched_alu_a_xo  output  WIDTH  registered operand A to the ALU.
- alu_sched_alu_b_xo  output  WIDTH  registered operand B to the ALU.
- alu_sched_alu_op_xo  output  3  registered opcode to the ALU.
- alu_sched_alu_f_xi  input  WIDTH  ALU result.
- alu_sched_alu_of_xi  input  1  ALU overflow flag.
- alu_sched_alu_zf_xi  input  1  ALU zero flag.
- alu_sched_rsp_valid_xo  output  1  response valid.
- alu_sched_rsp_ready_xi  input  1  consumer ready for the response.
- alu_sched_rsp_id_xo  output  1  requester the response belongs to.
- alu_sched_rsp_f_xo  output  WIDTH  captured result.
- alu_sched_rsp_of_xo  output  1  captured overflow flag.
- alu_sched_rsp_zf_xo  output  1  captured zero flag.
- alu_sched_busy_xo  output  1  high when state is not IDLE.
- alu_sched_op_cnt_xo  output  CNT_W  completed-response count.

Behaviour:
- Clock and reset: single clock alu_sched_clk_xi. Reset alu_sched_rst_n_xi is asynchronous, active-low, deasserted synchronously by the system.
- Reset values: state=IDLE; all ALU and response registers 0; rsp_valid=0; busy=0; op_cnt=0; last_grant=1, so requester 0 wins the first tie.
- States: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready_xo is combinational and high only in IDLE for the arbitration winner.
  - If exactly one valid is high, that requester wins.
  - If both are high, the requester != last_grant wins.
  - No valid: both ready=0, stay in IDLE.
- Accept edge (valid & ready): latch op/a/b into the alu_* registers, latch rsp_id, set last_grant=winner, load wait counter with ALU_LAT-1, go to EXEC.
- EXEC:
  - Counter decrements each cycle.
  - On the edge where the counter is 0, capture alu_f/of/zf into the rsp registers and go to RESP.
  - Net: response registers update exactly ALU_LAT edges after the accept edge.
- RESP:
  - rsp_valid=1; rsp fields held stable while rsp_ready=0.
  - On rsp_valid & rsp_ready edge: op_cnt += 1 (wraps 2^CNT_W-1 -> 0), go to IDLE.
  - No accept in the same cycle, because ready is only asserted in IDLE.
- Throughput: at most one operation per ALU_LAT+2 cycles.
- alu_* outputs hold the last issued operation until the next accept; no intermediate zeroing.
- Opcodes pass through unmodified, including unused codes; the scheduler does not interpret them.
- Requester-side valid dropped before acceptance: no effect, no accept.
- Reset asserted mid-EXEC or mid-RESP: in-flight operation discarded, no response emitted, all outputs return to reset values immediately.
- busy_xo = (state != IDLE).

Decomposition:
- Shared package alu_sched_pkg holds:
  - state encoding: IDLE=2'd0, EXEC=2'd1, RESP=2'd2;
  - ALU opcode width constant (3);
  - default WIDTH / ALU_LAT / CNT_W values.
- One sub-module, alu_sched_rr_arb2: combinational two-way round-robin arbiter. Inputs: two valids and last_grant. Outputs: one-hot grant and winner ID.
- FSM, counter and datapath registers live in the top module.

Test Plan:
- Bench ALU model: F=A^B, OF=0, ZF=(F==0), ALU_LAT=1.
- Reset check: hold rst_n=0 with random inputs -> all outputs 0, both ready=0, busy=0; release -> still idle, op_cnt=0.
- Single request: req0 valid, a=32'h0000_00FF, b=32'h0000_000F, op=3'd2 -> ready0 high one cycle; alu_op_xo=2 next cycle; rsp_valid one edge later with f=32'h0000_00F0, id=0, zf=0; rsp_ready=1 -> op_cnt=1, busy=0.
- Round-robin: both valid continuously, rsp_ready=1 -> grant order 0,1,0,1; four responses with ids 0,1,0,1; op_cnt=4; no starvation.
- Backpressure: rsp_ready=0 for 5 cycles with req1 pending -> rsp fields stable, ready1 stays 0; rsp_ready=1 -> then req1 accepted.
- Zero flag and counter wrap: a=b=32'h1234_5678 -> f=0, zf=1; CNT_W=2, five completions -> op_cnt sequence 1,2,3,0,1.
- Mid-operation reset: assert rst_n=0 during EXEC (ALU_LAT=4) -> rsp_valid never asserts for that operation; after release, the next request completes normally with op_cnt=1.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared constants for the ALU scheduler: state encoding, opcode width and
// default parameter values.
package alu_sched_pkg;

    localparam int unsigned OP_W        = 3;
    localparam int unsigned DEF_WIDTH   = 32;
    localparam int unsigned DEF_ALU_LAT = 1;
    localparam int unsigned DEF_CNT_W   = 16;
    localparam int unsigned LAT_W       = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_RESP = 2'd2;

endpackage

// File: rtl/alu_sched_if.sv
// Arbitration bundle between the scheduler core and its round-robin arbiter.
interface alu_sched_if;

    logic [1:0] req_valid;
    logic       last_grant;
    logic [1:0] grant;
    logic       winner;

    modport master (output req_valid, output last_grant, input grant, input winner);
    modport slave  (input req_valid, input last_grant, output grant, output winner);

endinterface

// File: rtl/alu_sched_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins outright, a tie goes to
// the requester that did not win last time.
module alu_sched_rr_arb2 (
    alu_sched_if.slave arb
);

    logic w_tie;
    logic w_any;

    assign w_tie      = &arb.req_valid;
    assign w_any      = |arb.req_valid;
    assign arb.winner = w_tie ? ~arb.last_grant : arb.req_valid[1];
    assign arb.grant  = !w_any     ? 2'b00 :
                        arb.winner ? 2'b10 : 2'b01;

endmodule

// File: rtl/alu_sched.sv
// Schedules operations from two requesters onto one shared ALU, one at a
// time, and returns each result tagged with the requester ID.
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned ALU_LAT = DEF_ALU_LAT,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic             alu_sched_clk_xi,
    input  logic             alu_sched_rst_n_xi,
    input  logic             alu_sched_req0_valid_xi,
    output logic             alu_sched_req0_ready_xo,
    input  logic [OP_W-1:0]  alu_sched_req0_op_xi,
    input  logic [WIDTH-1:0] alu_sched_req0_a_xi,
    input  logic [WIDTH-1:0] alu_sched_req0_b_xi,
    input  logic             alu_sched_req1_valid_xi,
    output logic             alu_sched_req1_ready_xo,
    input  logic [OP_W-1:0]  alu_sched_req1_op_xi,
    input  logic [WIDTH-1:0] alu_sched_req1_a_xi,
    input  logic [WIDTH-1:0] alu_sched_req1_b_xi,
    output logic [WIDTH-1:0] alu_sched_alu_a_xo,
    output logic [WIDTH-1:0] alu_sched_alu_b_xo,
    output logic [OP_W-1:0]  alu_sched_alu_op_xo,
    input  logic [WIDTH-1:0] alu_sched_alu_f_xi,
    input  logic             alu_sched_alu_of_xi,
    input  logic             alu_sched_alu_zf_xi,
    output logic             alu_sched_rsp_valid_xo,
    input  logic             alu_sched_rsp_ready_xi,
    output logic             alu_sched_rsp_id_xo,
    output logic [WIDTH-1:0] alu_sched_rsp_f_xo,
    output logic             alu_sched_rsp_of_xo,
    output logic             alu_sched_rsp_zf_xo,
    output logic             alu_sched_busy_xo,
    output logic [CNT_W-1:0] alu_sched_op_cnt_xo
);

    state_t           r_state;
    logic [LAT_W-1:0] r_wait;
    logic             r_last_grant;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [OP_W-1:0]  r_alu_op;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_f;
    logic             r_rsp_of;
    logic             r_rsp_zf;
    logic [CNT_W-1:0] r_op_cnt;

    logic             w_idle;
    logic             w_accept;
    logic             w_winner;

    alu_sched_if w_arb_if ();

    assign w_arb_if.req_valid  = {alu_sched_req1_valid_xi, alu_sched_req0_valid_xi};
    assign w_arb_if.last_grant = r_last_grant;
    assign w_winner            = w_arb_if.winner;

    alu_sched_rr_arb2 u_arb (
        .arb (w_arb_if)
    );

    // Ready is gated by reset so nothing looks accepted while reset is held.
    assign w_idle                  = (r_state == ST_IDLE) & alu_sched_rst_n_xi;
    assign alu_sched_req0_ready_xo = w_idle & w_arb_if.grant[0];
    assign alu_sched_req1_ready_xo = w_idle & w_arb_if.grant[1];
    assign w_accept                = alu_sched_req0_ready_xo | alu_sched_req1_ready_xo;

    always_ff @(posedge alu_sched_clk_xi or negedge alu_sched_rst_n_xi) begin
        if (!alu_sched_rst_n_xi) begin
            r_state      <= ST_IDLE;
            r_wait       <= '0;
            r_last_grant <= 1'b1;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_rsp_id     <= 1'b0;
            r_rsp_f      <= '0;
            r_rsp_of     <= 1'b0;
            r_rsp_zf     <= 1'b0;
            r_op_cnt     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_alu_a      <= w_winner ? alu_sched_req1_a_xi  : alu_sched_req0_a_xi;
                        r_alu_b      <= w_winner ? alu_sched_req1_b_xi  : alu_sched_req0_b_xi;
                        r_alu_op     <= w_winner ? alu_sched_req1_op_xi : alu_sched_req0_op_xi;
                        r_rsp_id     <= w_winner;
                        r_last_grant <= w_winner;
                        r_wait       <= LAT_W'(ALU_LAT - 1);
                        r_state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (r_wait == '0) begin
                        r_rsp_f  <= alu_sched_alu_f_xi;
                        r_rsp_of <= alu_sched_alu_of_xi;
                        r_rsp_zf <= alu_sched_alu_zf_xi;
                        r_state  <= ST_RESP;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (alu_sched_rsp_ready_xi) begin
                        r_op_cnt <= r_op_cnt + 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign alu_sched_alu_a_xo     = r_alu_a;
    assign alu_sched_alu_b_xo     = r_alu_b;
    assign alu_sched_alu_op_xo    = r_alu_op;
    assign alu_sched_rsp_valid_xo = (r_state == ST_RESP);
    assign alu_sched_rsp_id_xo    = r_rsp_id;
    assign alu_sched_rsp_f_xo     = r_rsp_f;
    assign alu_sched_rsp_of_xo    = r_rsp_of;
    assign alu_sched_rsp_zf_xo    = r_rsp_zf;
    assign alu_sched_busy_xo      = (r_state != ST_IDLE);
    assign alu_sched_op_cnt_xo    = r_op_cnt;

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: two instances (latency 1 / 16-bit count and latency 4 /
// 2-bit count) checked every cycle against a transaction-level model.
module tb_alu_sched;

    logic                  clk;
    logic [1:0]            rst_n;
    logic [1:0][1:0]       s_valid;
    logic [1:0][2:0]       s_op0, s_op1;
    logic [1:0][31:0]      s_a0, s_b0, s_a1, s_b1;
    logic [1:0]            s_rrdy;

    logic [1:0][1:0]       d_rdy;
    logic [1:0][31:0]      d_alu_a, d_alu_b, d_rsp_f, a_f;
    logic [1:0][2:0]       d_op;
    logic [1:0]            d_rv, d_id, d_of, d_zf, d_busy, a_zf;
    logic [15:0]           d_cnt0;
    logic [1:0]            d_cnt1;
    logic [1:0][15:0]      d_cnt;

    int n_checks = 0;
    int n_err    = 0;

    // model state, one slot per instance
    int unsigned           m_left [2];
    int unsigned           m_cnt  [2];
    logic [1:0]            m_hold, m_last, m_id, m_zf;
    logic [1:0][31:0]      m_a, m_b, m_f;
    logic [1:0][2:0]       m_op;
    int unsigned           c_lat  [2] = '{1, 4};
    int unsigned           c_mod  [2] = '{65536, 4};

    alu_sched_if u_if0 ();
    alu_sched_if u_if1 ();

    assign u_if0.req_valid  = s_valid[0];
    assign u_if1.req_valid  = s_valid[1];
    assign u_if0.last_grant = m_last[0];
    assign u_if1.last_grant = m_last[1];
    assign u_if0.winner     = m_id[0];
    assign u_if1.winner     = m_id[1];
    assign d_rdy[0]         = u_if0.grant;
    assign d_rdy[1]         = u_if1.grant;
    assign d_cnt[0]         = d_cnt0;
    assign d_cnt[1]         = {14'd0, d_cnt1};

    // bench ALU: F = A ^ B, OF = 0, ZF = (F == 0)
    assign a_f[0]  = d_alu_a[0] ^ d_alu_b[0];
    assign a_f[1]  = d_alu_a[1] ^ d_alu_b[1];
    assign a_zf[0] = (a_f[0] == 32'd0);
    assign a_zf[1] = (a_f[1] == 32'd0);

    alu_sched #(.WIDTH(32), .ALU_LAT(1), .CNT_W(16)) u_dut0 (
        .alu_sched_clk_xi        (clk),
        .alu_sched_rst_n_xi      (rst_n[0]),
        .alu_sched_req0_valid_xi (u_if0.req_valid[0]),
        .alu_sched_req0_ready_xo (u_if0.grant[0]),
        .alu_sched_req0_op_xi    (s_op0[0]),
        .alu_sched_req0_a_xi     (s_a0[0]),
        .alu_sched_req0_b_xi     (s_b0[0]),
        .alu_sched_req1_valid_xi (u_if0.req_valid[1]),
        .alu_sched_req1_ready_xo (u_if0.grant[1]),
        .alu_sched_req1_op_xi    (s_op1[0]),
        .alu_sched_req1_a_xi     (s_a1[0]),
        .alu_sched_req1_b_xi     (s_b1[0]),
        .alu_sched_alu_a_xo      (d_alu_a[0]),
        .alu_sched_alu_b_xo      (d_alu_b[0]),
        .alu_sched_alu_op_xo     (d_op[0]),
        .alu_sched_alu_f_xi      (a_f[0]),
        .alu_sched_alu_of_xi     (1'b0),
        .alu_sched_alu_zf_xi     (a_zf[0]),
        .alu_sched_rsp_valid_xo  (d_rv[0]),
        .alu_sched_rsp_ready_xi  (s_rrdy[0]),
        .alu_sched_rsp_id_xo     (d_id[0]),
        .alu_sched_rsp_f_xo      (d_rsp_f[0]),
        .alu_sched_rsp_of_xo     (d_of[0]),
        .alu_sched_rsp_zf_xo     (d_zf[0]),
        .alu_sched_busy_xo       (d_busy[0]),
        .alu_sched_op_cnt_xo     (d_cnt0)
    );

    alu_sched #(.WIDTH(32), .ALU_LAT(4), .CNT_W(2)) u_dut1 (
        .alu_sched_clk_xi        (clk),
        .alu_sched_rst_n_xi      (rst_n[1]),
        .alu_sched_req0_valid_xi (u_if1.req_valid[0]),
        .alu_sched_req0_ready_xo (u_if1.grant[0]),
        .alu_sched_req0_op_xi    (s_op0[1]),
        .alu_sched_req0_a_xi     (s_a0[1]),
        .alu_sched_req0_b_xi     (s_b0[1]),
        .alu_sched_req1_valid_xi (u_if1.req_valid[1]),
        .alu_sched_req1_ready_xo (u_if1.grant[1]),
        .alu_sched_req1_op_xi    (s_op1[1]),
        .alu_sched_req1_a_xi     (s_a1[1]),
        .alu_sched_req1_b_xi     (s_b1[1]),
        .alu_sched_alu_a_xo      (d_alu_a[1]),
        .alu_sched_alu_b_xo      (d_alu_b[1]),
        .alu_sched_alu_op_xo     (d_op[1]),
        .alu_sched_alu_f_xi      (a_f[1]),
        .alu_sched_alu_of_xi     (1'b0),
        .alu_sched_alu_zf_xi     (a_zf[1]),
        .alu_sched_rsp_valid_xo  (d_rv[1]),
        .alu_sched_rsp_ready_xi  (s_rrdy[1]),
        .alu_sched_rsp_id_xo     (d_id[1]),
        .alu_sched_rsp_f_xo      (d_rsp_f[1]),
        .alu_sched_rsp_of_xo     (d_of[1]),
        .alu_sched_rsp_zf_xo     (d_zf[1]),
        .alu_sched_busy_xo       (d_busy[1]),
        .alu_sched_op_cnt_xo     (d_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    function automatic logic model_winner(input int k);
        return (s_valid[k] == 2'b11) ? ~m_last[k] : s_valid[k][1];
    endfunction

    function automatic logic model_idle(input int k);
        return rst_n[k] && (m_left[k] == 0) && !m_hold[k];
    endfunction

    task automatic model_reset(input int k);
        m_left[k] = 0; m_cnt[k] = 0; m_hold[k] = 0; m_last[k] = 1; m_id[k] = 0;
        m_a[k] = '0; m_b[k] = '0; m_f[k] = '0; m_op[k] = '0; m_zf[k] = 0;
    endtask

    task automatic model_edge(input int k);
        logic w;
        if (m_hold[k]) begin
            if (s_rrdy[k]) begin
                m_hold[k] = 0;
                m_cnt[k]  = (m_cnt[k] + 1) % c_mod[k];
            end
        end else if (m_left[k] != 0) begin
            m_left[k]--;
            if (m_left[k] == 0) begin
                m_f[k]    = m_a[k] ^ m_b[k];
                m_zf[k]   = (m_f[k] == 32'd0);
                m_hold[k] = 1;
            end
        end else if (s_valid[k] != 2'b00) begin
            w         = model_winner(k);
            m_id[k]   = w;
            m_last[k] = w;
            m_a[k]    = w ? s_a1[k]  : s_a0[k];
            m_b[k]    = w ? s_b1[k]  : s_b0[k];
            m_op[k]   = w ? s_op1[k] : s_op0[k];
            m_left[k] = c_lat[k];
        end
    endtask

    always @(posedge clk or negedge rst_n[0]) begin
        if (!rst_n[0]) model_reset(0);
        else           model_edge(0);
    end

    always @(posedge clk or negedge rst_n[1]) begin
        if (!rst_n[1]) model_reset(1);
        else           model_edge(1);
    end

    task automatic compare(input int k);
        logic [1:0] er;
        er = 2'b00;
        if (model_idle(k) && s_valid[k] != 2'b00)
            er = model_winner(k) ? 2'b10 : 2'b01;
        chk($sformatf("u%0d.ready", k),     d_rdy[k],   er);
        chk($sformatf("u%0d.busy", k),      d_busy[k],  (m_left[k] != 0) || m_hold[k]);
        chk($sformatf("u%0d.rsp_valid", k), d_rv[k],    m_hold[k]);
        chk($sformatf("u%0d.rsp_id", k),    d_id[k],    m_id[k]);
        chk($sformatf("u%0d.rsp_f", k),     d_rsp_f[k], m_f[k]);
        chk($sformatf("u%0d.rsp_of", k),    d_of[k],    1'b0);
        chk($sformatf("u%0d.rsp_zf", k),    d_zf[k],    m_zf[k]);
        chk($sformatf("u%0d.alu_a", k),     d_alu_a[k], m_a[k]);
        chk($sformatf("u%0d.alu_b", k),     d_alu_b[k], m_b[k]);
        chk($sformatf("u%0d.alu_op", k),    d_op[k],    m_op[k]);
        chk($sformatf("u%0d.op_cnt", k),    d_cnt[k],   m_cnt[k]);
    endtask

    always @(negedge clk) begin
        compare(0);
        compare(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_req(input int k, input int id, input logic [31:0] a,
                           input logic [31:0] b, input logic [2:0] op);
        if (id == 0) begin s_a0[k] = a; s_b0[k] = b; s_op0[k] = op; end
        else         begin s_a1[k] = a; s_b1[k] = b; s_op1[k] = op; end
        s_valid[k][id] = 1'b1;
    endtask

    task automatic wait_ready(input int k, input int id);
        for (int unsigned t = 0; t < 20 && !d_rdy[k][id]; t++) tick(1);
        chk($sformatf("u%0d.wait_ready%0d", k, id), d_rdy[k][id], 1'b1);
    endtask

    task automatic wait_rsp(input int k);
        for (int unsigned t = 0; t < 30 && !d_rv[k]; t++) tick(1);
        chk($sformatf("u%0d.wait_rsp", k), d_rv[k], 1'b1);
    endtask

    task automatic run_one(input int k, input int id, input logic [31:0] a,
                           input logic [31:0] b, input logic [2:0] op);
        set_req(k, id, a, b, op);
        #1;
        wait_ready(k, id);
        tick(1);
        s_valid[k][id] = 1'b0;
        wait_rsp(k);
        s_rrdy[k] = 1'b1;
        tick(1);
        #1;
    endtask

    task automatic pulse_reset(input int k);
        rst_n[k] = 1'b0;
        tick(2);
        rst_n[k] = 1'b1;
    endtask

    int unsigned q_grant[$];
    int unsigned q_rid[$];
    int unsigned exp_rr[4]   = '{0, 1, 0, 1};
    int unsigned exp_wrap[5] = '{1, 2, 3, 0, 1};

    initial begin
        model_reset(0);
        model_reset(1);
        rst_n   = 2'b00;
        s_valid = '0; s_op0 = '0; s_op1 = '0;
        s_a0 = '0; s_b0 = '0; s_a1 = '0; s_b1 = '0;
        s_rrdy  = 2'b00;

        // reset held with random inputs
        for (int unsigned i = 0; i < 4; i++) begin
            for (int k = 0; k < 2; k++) begin
                s_valid[k] = 2'($urandom); s_rrdy[k] = 1'($urandom);
                s_a0[k] = $urandom; s_b0[k] = $urandom; s_op0[k] = 3'($urandom);
                s_a1[k] = $urandom; s_b1[k] = $urandom; s_op1[k] = 3'($urandom);
            end
            tick(1);
            #1;
            chk("reset.ready0", d_rdy[0], 2'b00);
            chk("reset.busy0",  d_busy[0], 1'b0);
        end
        s_valid = '0;
        s_rrdy  = 2'b11;
        rst_n   = 2'b11;
        tick(1);
        #1;
        chk("release.busy0", d_busy[0], 1'b0);
        chk("release.cnt0",  d_cnt0, 16'd0);

        // single request on requester 0
        set_req(0, 0, 32'h0000_00FF, 32'h0000_000F, 3'd2);
        #1;
        chk("single.ready0", d_rdy[0], 2'b01);
        tick(1);
        s_valid[0] = 2'b00;
        #1;
        chk("single.alu_op", d_op[0], 3'd2);
        chk("single.rv_early", d_rv[0], 1'b0);
        tick(1);
        #1;
        chk("single.rv", d_rv[0], 1'b1);
        chk("single.f",  d_rsp_f[0], 32'h0000_00F0);
        chk("single.id", d_id[0], 1'b0);
        chk("single.zf", d_zf[0], 1'b0);
        tick(1);
        #1;
        chk("single.cnt",  d_cnt0, 16'd1);
        chk("single.busy", d_busy[0], 1'b0);

        // round-robin with both requesters always valid
        pulse_reset(0);
        set_req(0, 0, 32'h0000_0011, 32'h0000_0022, 3'd0);
        set_req(0, 1, 32'h0000_0F00, 32'h0000_00F0, 3'd1);
        for (int unsigned t = 0; t < 60 && q_rid.size() < 4; t++) begin
            if (q_grant.size() == 4) s_valid[0] = 2'b00;
            #1;
            if (d_rdy[0][0]) q_grant.push_back(0);
            if (d_rdy[0][1]) q_grant.push_back(1);
            if (d_rv[0])     q_rid.push_back(d_id[0]);
            tick(1);
        end
        s_valid[0] = 2'b00;
        chk("rr.n_grants", q_grant.size(), 4);
        chk("rr.n_rsp",    q_rid.size(), 4);
        for (int unsigned i = 0; i < 4; i++) begin
            if (i < q_grant.size()) chk($sformatf("rr.grant%0d", i), q_grant[i], exp_rr[i]);
            if (i < q_rid.size())   chk($sformatf("rr.id%0d", i),    q_rid[i],   exp_rr[i]);
        end
        #1;
        chk("rr.cnt", d_cnt0, 16'd4);

        // backpressure while requester 1 waits
        s_rrdy[0] = 1'b0;
        set_req(0, 0, 32'hAAAA_0000, 32'h0000_BBBB, 3'd3);
        #1;
        wait_ready(0, 0);
        tick(1);
        s_valid[0] = 2'b00;
        set_req(0, 1, 32'h0000_0001, 32'h0000_0003, 3'd5);
        wait_rsp(0);
        for (int unsigned i = 0; i < 5; i++) begin
            #1;
            chk("bp.f_hold", d_rsp_f[0], 32'hAAAA_BBBB);
            chk("bp.ready1", d_rdy[0][1], 1'b0);
            tick(1);
        end
        s_rrdy[0] = 1'b1;
        tick(1);
        #1;
        chk("bp.ready1_after", d_rdy[0][1], 1'b1);
        tick(1);
        s_valid[0] = 2'b00;
        wait_rsp(0);
        #1;
        chk("bp.id1", d_id[0], 1'b1);
        chk("bp.f1",  d_rsp_f[0], 32'h0000_0002);
        tick(1);
        #1;
        chk("bp.cnt", d_cnt0, 16'd6);

        // zero flag, unused opcode passes through
        run_one(0, 0, 32'h1234_5678, 32'h1234_5678, 3'd7);
        chk("zf.f",  d_rsp_f[0], 32'd0);
        chk("zf.zf", d_zf[0], 1'b1);
        chk("zf.op", d_op[0], 3'd7);

        // 2-bit counter wrap on the latency-4 instance
        for (int unsigned i = 0; i < 5; i++) begin
            run_one(1, int'(i % 2), 32'h100 + i, 32'h1, 3'(i));
            chk($sformatf("wrap.cnt%0d", i), d_cnt1, 2'(exp_wrap[i]));
        end

        // reset during EXEC drops the in-flight operation
        set_req(1, 0, 32'h0000_0005, 32'h0000_0006, 3'd4);
        #1;
        wait_ready(1, 0);
        tick(1);
        s_valid[1] = 2'b00;
        tick(1);
        #1;
        chk("midrst.busy", d_busy[1], 1'b1);
        rst_n[1] = 1'b0;
        for (int unsigned i = 0; i < 6; i++) begin
            #1;
            chk("midrst.rv", d_rv[1], 1'b0);
            tick(1);
        end
        rst_n[1] = 1'b1;
        #1;
        chk("midrst.cnt0", d_cnt1, 2'd0);
        chk("midrst.idle", d_busy[1], 1'b0);
        for (int unsigned i = 0; i < 6; i++) begin
            #1;
            chk("midrst.no_rsp", d_rv[1], 1'b0);
            tick(1);
        end
        run_one(1, 1, 32'h0000_F0F0, 32'h0000_0F0F, 3'd6);
        chk("midrst.cnt1", d_cnt1, 2'd1);
        chk("midrst.f",    d_rsp_f[1], 32'h0000_FFFF);
        chk("midrst.id",   d_id[1], 1'b1);

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
